lfsr_multi: RTL and testbench

Parametrised successor to the single-mode LFSR. It supports Galois and Fibonacci modes, a runtime seed/tap/mode load, a valid/ready output handshake with backpressure, and all-zero lockup detection. An optional period-measurement unit can be compiled in. It sits between the configuration register file and pattern consumers (PWM, scramblers, test-pattern outputs).

---
 rtl/lfsr_multi.sv | 157 +++++++++++++++
 tb/tb_lfsr_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_multi.sv
// lfsr_multi: runtime-configurable Galois/Fibonacci LFSR with a TICKS prescaler,
// a valid/ready output handshake with backpressure, and all-zero lockup flag.
// Optional period-measurement unit is built when LFSR_PERIOD_EN is defined;
// otherwise period_o / period_valid_o are tied to zero.
module lfsr_multi #(
  parameter int unsigned     BITS  = 16,
  parameter int unsigned     TICKS = 1,
  parameter logic [BITS-1:0] SEED  = BITS'(16'h0001),
  parameter logic [BITS-1:0] TAPS  = BITS'(16'hB400)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [BITS-1:0] seed_i,
  input  logic [BITS-1:0] taps_i,
  input  logic            mode_i,
  input  logic            run_i,
  input  logic            out_ready_i,
  output logic [BITS-1:0] state_o,
  output logic            out_valid_o,
  output logic            lockup_o,
  output logic [BITS-1:0] period_o,
  output logic            period_valid_o
);

  localparam int unsigned     TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS - 1);

  logic [BITS-1:0] state_q, state_d;
  logic [BITS-1:0] taps_q, taps_d;
  logic            mode_q, mode_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            valid_q, valid_d;
  logic            lockup_q;

  logic [BITS-1:0] galois_nxt;
  logic [BITS-1:0] fib_nxt;
  logic            fib_fb;
  logic [BITS-1:0] lfsr_nxt;
  logic            stall;
  logic            adv;

  // Successor of the current state in both modes; mode selects which is used.
  always_comb begin
    galois_nxt = {1'b0, state_q[BITS-1:1]} ^ (state_q[0] ? taps_q : '0);
    fib_fb     = ^(state_q & taps_q);
    fib_nxt    = {fib_fb, state_q[BITS-1:1]};
    lfsr_nxt   = mode_q ? fib_nxt : galois_nxt;
  end

  // A presented but unaccepted state freezes the prescaler; load always wins.
  assign stall = valid_q & ~out_ready_i;
  assign adv   = ~load_i & run_i & ~stall & (tick_q == TICK_LAST);

  // Next-state for LFSR, prescaler and handshake.
  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    valid_d = valid_q;
    if (load_i) begin
      state_d = seed_i;
      taps_d  = taps_i;
      mode_d  = mode_i;
      tick_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (run_i && !stall) begin
        tick_d = adv ? '0 : tick_q + TW'(1);
      end
      if (adv) begin
        state_d = lfsr_nxt;
        valid_d = 1'b1;
      end else if (valid_q && out_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // Core registers; lockup is a one-cycle-late decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED;
      taps_q   <= TAPS;
      mode_q   <= 1'b0;
      tick_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      lockup_q <= (state_q == '0);
    end
  end

  assign state_o     = state_q;
  assign out_valid_o = valid_q;
  assign lockup_o    = lockup_q;

`ifdef LFSR_PERIOD_EN
  logic [BITS-1:0] seed_q;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] period_q, period_d;
  logic            pvalid_q, pvalid_d;
  logic            adv_q;
  logic            match;

  // Returning to the seed is seen one cycle after the advance that landed there;
  // the zero state never counts as a return so a zero seed never reports.
  assign match = adv_q & (state_q == seed_q) & (|state_q);

  // Period counter: counts advances, latches on seed return, saturates.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    if (load_i) begin
      cnt_d    = '0;
      pvalid_d = 1'b0;
    end else if (match) begin
      period_d = cnt_q;
      pvalid_d = 1'b1;
      cnt_d    = adv ? BITS'(1) : '0;
    end else if (adv && (cnt_q != '1)) begin
      cnt_d = cnt_q + BITS'(1);
    end
  end

  // Period-unit registers, including the seed copy used for the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      seed_q   <= load_i ? seed_i : seed_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      adv_q    <= adv;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: random + directed checks of lfsr_multi against a behavioural model.
// Three instances: 4-bit TICKS=1, 4-bit TICKS=3, and the 16-bit default.
module tb_lfsr_multi;

`ifdef LFSR_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // instance A: BITS=4, TICKS=1
  logic       a_load = 1'b0, a_mode = 1'b0, a_run = 1'b0, a_rdy = 1'b0;
  logic [3:0] a_seed = '0, a_taps = '0;
  logic [3:0] a_state, a_per;
  logic       a_valid, a_lock, a_pv;
  // instance B: BITS=4, TICKS=3
  logic       b_load = 1'b0, b_mode = 1'b0, b_run = 1'b0, b_rdy = 1'b0;
  logic [3:0] b_seed = '0, b_taps = '0;
  logic [3:0] b_state, b_per;
  logic       b_valid, b_lock, b_pv;
  // instance C: defaults
  logic        c_load = 1'b0, c_mode = 1'b0, c_run = 1'b0, c_rdy = 1'b0;
  logic [15:0] c_seed = '0, c_taps = '0;
  logic [15:0] c_state, c_per;
  logic        c_valid, c_lock, c_pv;

  lfsr_multi #(.BITS(4), .TICKS(1), .SEED(4'h1), .TAPS(4'hC)) u_a (
    .clk(clk), .rst_n(rst_n), .load_i(a_load), .seed_i(a_seed), .taps_i(a_taps),
    .mode_i(a_mode), .run_i(a_run), .out_ready_i(a_rdy), .state_o(a_state),
    .out_valid_o(a_valid), .lockup_o(a_lock), .period_o(a_per), .period_valid_o(a_pv));

  lfsr_multi #(.BITS(4), .TICKS(3), .SEED(4'h1), .TAPS(4'hC)) u_b (
    .clk(clk), .rst_n(rst_n), .load_i(b_load), .seed_i(b_seed), .taps_i(b_taps),
    .mode_i(b_mode), .run_i(b_run), .out_ready_i(b_rdy), .state_o(b_state),
    .out_valid_o(b_valid), .lockup_o(b_lock), .period_o(b_per), .period_valid_o(b_pv));

  lfsr_multi u_c (
    .clk(clk), .rst_n(rst_n), .load_i(c_load), .seed_i(c_seed), .taps_i(c_taps),
    .mode_i(c_mode), .run_i(c_run), .out_ready_i(c_rdy), .state_o(c_state),
    .out_valid_o(c_valid), .lockup_o(c_lock), .period_o(c_per), .period_valid_o(c_pv));

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LFSR successor straight from the shift/tap rules, in integer arithmetic.
  function automatic int step_lfsr(input int s, input int t, input bit fibo, input int w);
    if (fibo) return (($countones(s & t) % 2) << (w - 1)) | (s >> 1);
    return ((s % 2) == 1) ? ((s >> 1) ^ t) : (s >> 1);
  endfunction

  // Reference model for instance B (values after the next clock edge).
  int m_state = 1, m_taps = 12, m_seed = 1, m_tick = 0, m_cnt = 0, m_per = 0;
  bit m_fib = 0, m_valid = 0, m_lock = 0, m_pv = 0, m_adv_prev = 0;

  task automatic model_b(input bit ld, input int sd, input int tp, input bit md,
                         input bit run, input bit rdy);
    bit stall, adv, hit;
    stall = m_valid && !rdy;
    adv   = !ld && run && !stall && (m_tick == 2);
    hit   = m_adv_prev && (m_state == m_seed) && (m_state != 0);
    m_lock = (m_state == 0);
    if (ld) begin
      m_cnt = 0;
      m_pv  = 0;
    end else if (hit) begin
      m_per = m_cnt;
      m_pv  = 1;
      m_cnt = adv ? 1 : 0;
    end else if (adv && m_cnt != 15) begin
      m_cnt++;
    end
    m_adv_prev = adv;
    if (ld) begin
      m_state = sd; m_taps = tp; m_fib = md; m_seed = sd; m_tick = 0; m_valid = 0;
    end else begin
      if (run && !stall) m_tick = adv ? 0 : m_tick + 1;
      if (adv) begin
        m_state = step_lfsr(m_state, m_taps, m_fib, 4);
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    int s;
    logic [3:0] gal_ref [4];
    logic [3:0] fib_ref [4];
    gal_ref = '{4'hC, 4'h6, 4'h3, 4'hD};
    fib_ref = '{4'h8, 4'h4, 4'h2, 4'h9};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_a_state", a_state, 1);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_lock",  a_lock,  0);
    check("rst_a_per",   a_per,   0);
    check("rst_a_pv",    a_pv,    0);
    check("rst_c_state", c_state, 16'h0001);
    check("rst_c_valid", c_valid, 0);
    rst_n = 1'b1;

    // randomized traffic on B against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit ld, md, rn, rd;
      int sd, tp;
      @(negedge clk);
      check("rnd_state", b_state, m_state);
      check("rnd_valid", b_valid, m_valid);
      check("rnd_lock",  b_lock,  m_lock);
      check("rnd_per",   b_per,   PEN ? m_per : 0);
      check("rnd_pv",    b_pv,    PEN ? m_pv : 0);
      ld = ($urandom_range(0, 39) == 0);
      sd = $urandom_range(0, 15);
      tp = $urandom_range(0, 15);
      md = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 9) < 8);
      rd = 1'($urandom_range(0, 1));
      b_load = ld; b_seed = 4'(sd); b_taps = 4'(tp); b_mode = md; b_run = rn; b_rdy = rd;
      model_b(ld, sd, tp, md, rn, rd);
    end

    // A: Galois sequence and period 15
    @(negedge clk);
    a_load = 1'b1; a_seed = 4'h1; a_taps = 4'hC; a_mode = 1'b0; a_rdy = 1'b1; a_run = 1'b0;
    @(negedge clk);
    a_load = 1'b0; a_run = 1'b1;
    check("gal_load_state", a_state, 1);
    check("gal_load_valid", a_valid, 0);
    s = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      s = step_lfsr(s, 12, 1'b0, 4);
      check("gal_state", a_state, (k <= 4) ? 32'(gal_ref[k-1]) : s);
      check("gal_valid", a_valid, 1);
    end
    check("gal_wrap", a_state, 1);
    check("gal_pv_lag", a_pv, 0);
    @(negedge clk);
    check("gal_pv",  a_pv,  PEN ? 1 : 0);
    check("gal_per", a_per, PEN ? 15 : 0);

    // A: load coincident with advance and accept, then Fibonacci sequence
    a_load = 1'b1; a_seed = 4'h1; a_taps = 4'h3; a_mode = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    check("ldadv_state", a_state, 1);
    check("ldadv_valid", a_valid, 0);
    check("ldadv_pv",    a_pv,    0);
    s = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      s = step_lfsr(s, 3, 1'b1, 4);
      check("fib_state", a_state, (k <= 4) ? 32'(fib_ref[k-1]) : s);
    end
    check("fib_wrap", a_state, 1);
    @(negedge clk);
    check("fib_pv",  a_pv,  PEN ? 1 : 0);
    check("fib_per", a_per, PEN ? 15 : 0);

    // A: zero seed locks up, period never reported
    a_load = 1'b1; a_seed = 4'h0; a_taps = 4'hC; a_mode = 1'b0;
    @(negedge clk);
    a_load = 1'b0;
    check("zero_state",    a_state, 0);
    check("zero_lock_lag", a_lock,  0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("zero_hold", a_state, 0);
      check("zero_lock", a_lock,  1);
      check("zero_pv",   a_pv,    0);
    end
    a_load = 1'b1; a_seed = 4'h1; a_run = 1'b0;
    @(negedge clk);
    a_load = 1'b0;
    check("unlock_state", a_state, 1);
    @(negedge clk);
    check("unlock_lock", a_lock, 0);

    // B: backpressure freezes state and prescaler
    b_load = 1'b1; b_seed = 4'h1; b_taps = 4'hC; b_mode = 1'b0; b_run = 1'b1; b_rdy = 1'b0;
    @(negedge clk);
    b_load = 1'b0;
    check("stl_load", b_state, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stl_pre_state", b_state, 1);
      check("stl_pre_valid", b_valid, 0);
    end
    @(negedge clk);
    check("stl_adv_state", b_state, 4'hC);
    check("stl_adv_valid", b_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stl_hold_state", b_state, 4'hC);
      check("stl_hold_valid", b_valid, 1);
    end
    b_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("acc_valid", b_valid, 0);
      check("acc_state", b_state, 4'hC);
    end
    @(negedge clk);
    check("acc_next_state", b_state, 4'h6);
    check("acc_next_valid", b_valid, 1);

    // B: load on the advance edge resets the prescaler
    repeat (2) @(negedge clk);
    b_load = 1'b1; b_seed = 4'h9;
    @(negedge clk);
    b_load = 1'b0;
    check("ldtick_state", b_state, 4'h9);
    check("ldtick_valid", b_valid, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("ldtick_wait", b_state, 4'h9);
    end
    @(negedge clk);
    check("ldtick_adv", b_state, 4'h8);
    check("ldtick_adv_valid", b_valid, 1);

    // B: asynchronous reset while stalled
    b_rdy = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", b_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", b_valid, 0);
    check("async_rst_state", b_state, 1);
    check("async_rst_c",     c_state, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    b_run = 1'b0;

    // C: default taps run a full maximal period
    c_run = 1'b1; c_rdy = 1'b1;
    s = 1;
    for (int k = 1; k <= 65535; k++) begin
      @(negedge clk);
      s = step_lfsr(s, 16'hB400, 1'b0, 16);
      if (k <= 4 || (k % 4096) == 0) check("c_state", c_state, s);
    end
    check("c_wrap",  c_state, 16'h0001);
    check("c_valid", c_valid, 1);
    @(negedge clk);
    check("c_pv",  c_pv,  PEN ? 1 : 0);
    check("c_per", c_per, PEN ? 65535 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
